// File: rtl/systolic_writeback_pkg.sv
// Shared sizing, defaults and FSM state type for the systolic writeback block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default geometry of the conv output matrix, the writeback state
// enum and two small constant helpers used for counter sizing.
package systolic_writeback_pkg;

  localparam int          WB_M           = 20;            // output rows (IMG_H*IMG_W)
  localparam int          WB_K           = 5;             // output lanes (FILTER_NUM)
  localparam int          WB_DATA_WIDTH  = 32;
  localparam int          WB_ADDR_WIDTH  = 32;
  localparam logic [31:0] WB_OUTPUT_BASE = 32'h0000_3000;
  localparam int          WB_LAT         = 10;            // start -> lane 0 of row 0

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } wb_state_e;

  // Cycle index (relative to the start edge) of the final lane capture:
  // lane K-1 of row M-1.
  function automatic int last_capture_cycle(input int lat, input int m, input int k);
    return lat + m + k - 2;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/systolic_writeback_if.sv
// Bundle between the systolic drain logic and the output memory writer.
// Latency: n/a (wires only).
// Backpressure: none; the memory side must accept one word per cycle.
//
// Signals: start pulse and skewed Y vector in; addr_wr/data_wr/mem_wr_en
// write port and done level out. slave = the writeback block, master = driver.
interface systolic_writeback_if
  import systolic_writeback_pkg::*;
#(
  parameter int K          = WB_K,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) ();

  logic                    start;
  logic [DATA_WIDTH*K-1:0] Y;
  logic [ADDR_WIDTH-1:0]   addr_wr;
  logic [DATA_WIDTH-1:0]   data_wr;
  logic                    mem_wr_en;
  logic                    done;

  modport master (
    output start, Y,
    input  addr_wr, data_wr, mem_wr_en, done
  );

  modport slave (
    input  start, Y,
    output addr_wr, data_wr, mem_wr_en, done
  );

endinterface

// File: rtl/systolic_writeback_wb_buffer.sv
// M*K word register file holding the deskewed result matrix.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; every lane write enable is honoured on its edge.
//
// Ports: clk; lane_we/lane_row per lane (lane k of row lane_row[k] goes to
// word lane_row[k]*K+k); lane_dat = raw Y vector; rd_idx/rd_dat read port.
module systolic_writeback_wb_buffer
  import systolic_writeback_pkg::*;
#(
  parameter int  M          = WB_M,
  parameter int  K          = WB_K,
  parameter int  DATA_WIDTH = WB_DATA_WIDTH,
  localparam int RW         = cnt_width(M - 1),
  localparam int JW         = cnt_width(M * K - 1)
) (
  input  logic                    clk,
  input  logic [K-1:0]            lane_we,
  input  logic [K-1:0][RW-1:0]    lane_row,
  input  logic [DATA_WIDTH*K-1:0] lane_dat,
  input  logic [JW-1:0]           rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_dat
);

  logic [M*K-1:0][DATA_WIDTH-1:0] words;

  // One register per word; each word listens only to its own lane, so the
  // per-word enable is just "my lane is writing my row".
  for (genvar i = 0; i < M * K; i++) begin : g_word
    localparam int WM = i / K;
    localparam int WK = i % K;
    logic [DATA_WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
      if (lane_we[WK] && (int'(lane_row[WK]) == WM)) begin
        word_q <= lane_dat[WK*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign words[i] = word_q;
  end

  // Write-through: the very first read is issued on the same edge as the last
  // capture. Only when the matrix is a single word do those coincide, but the
  // bypass is written generically.
  always_comb begin
    rd_dat = words[rd_idx];
    for (int k = 0; k < K; k++) begin
      if (lane_we[k] && ((int'(lane_row[k]) * K + k) == int'(rd_idx))) begin
        rd_dat = lane_dat[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/systolic_writeback.sv
// Deskews the systolic Y vector into a buffer, then writes the M x K result to OUTPUT_BASE.
// Latency: first write visible after edge LAT+M+K-2 (start edge = 0); done after a further M*K edges.
// Backpressure: none; one word per cycle, start is ignored while capturing or writing.
//
// Ports: clk, rst (async, active low); bus (slave): start, Y in;
// addr_wr, data_wr, mem_wr_en, done out (all outputs registered).
module systolic_writeback
  import systolic_writeback_pkg::*;
#(
  parameter int                    M           = WB_M,
  parameter int                    K           = WB_K,
  parameter int                    DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(WB_OUTPUT_BASE),
  parameter int                    LAT         = WB_LAT
) (
  input logic                 clk,
  input logic                 rst,
  systolic_writeback_if.slave bus
);

  localparam int LAST_CAP = last_capture_cycle(LAT, M, K);
  localparam int NWORDS   = M * K;
  localparam int CW       = cnt_width(LAST_CAP);
  localparam int JW       = cnt_width(NWORDS - 1);
  localparam int RW       = cnt_width(M - 1);

  wb_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;     // cycle index c of the next edge while capturing
  logic [JW-1:0]         wcnt_q, wcnt_d;   // index j of the write currently on the bus
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d;
  logic                  done_q, done_d;

  logic                  cap_phase;
  logic                  last_cap;
  int                    c_now;
  logic [K-1:0]          lane_we;
  logic [K-1:0][RW-1:0]  lane_row;
  logic [JW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_dat;

  // Capture window. The start edge itself is c=0, so a start seen in IDLE or
  // DONE already counts as a capture edge (matters when LAT=0).
  always_comb begin
    lane_we   = '0;
    lane_row  = '0;
    cap_phase = (state_q == ST_CAPTURE) ||
                (((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start);
    c_now     = (state_q == ST_CAPTURE) ? int'(cnt_q) : 0;
    last_cap  = cap_phase && (c_now == LAST_CAP);
    for (int k = 0; k < K; k++) begin
      // Lane k carries row m at c = LAT + m + k; anything else is ignored.
      if (cap_phase && ((c_now - LAT - k) >= 0) && ((c_now - LAT - k) < M)) begin
        lane_we[k]  = 1'b1;
        lane_row[k] = RW'(c_now - LAT - k);
      end
    end
  end

  // Read one word ahead so the registered outputs carry word j while j is on the bus.
  assign rd_idx = ((state_q == ST_WRITE) && (int'(wcnt_q) != NWORDS - 1)) ?
                  wcnt_q + JW'(1) : '0;

  systolic_writeback_wb_buffer #(
    .M          (M),
    .K          (K),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wb_buffer (
    .clk      (clk),
    .lane_we  (lane_we),
    .lane_row (lane_row),
    .lane_dat (bus.Y),
    .rd_idx   (rd_idx),
    .rd_dat   (rd_dat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_CAPTURE: begin
        if (cap_phase) begin
          done_d = 1'b0;
          if (last_cap) begin
            // Word 0 goes out in the cycle right after the final capture.
            state_d = ST_WRITE;
            cnt_d   = '0;
            wcnt_d  = '0;
            addr_d  = OUTPUT_BASE;
            data_d  = rd_dat;
            en_d    = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
            cnt_d   = CW'(c_now + 1);
          end
        end
      end
      ST_WRITE: begin
        if (int'(wcnt_q) == NWORDS - 1) begin
          state_d = ST_DONE;
          wcnt_d  = '0;
          addr_d  = '0;
          data_d  = '0;
          en_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + JW'(1);
          addr_d = OUTPUT_BASE + ADDR_WIDTH'(int'(wcnt_q) + 1);
          data_d = rd_dat;
          en_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign bus.addr_wr   = addr_q;
  assign bus.data_wr   = data_q;
  assign bus.mem_wr_en = en_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_writeback.sv
// Bench for systolic_writeback: default 20x5 geometry plus a 1x1, LAT=0 instance.
// Expected writes come from the Y values the bench drove, indexed by the capture rule c = LAT+m+k.
module tb_systolic_writeback;
  import systolic_writeback_pkg::*;

  localparam int          M    = 20;
  localparam int          K    = 5;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          LAT  = 10;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam int          LC   = LAT + M + K - 2;  // edge of the last capture
  localparam int          NW   = M * K;
  localparam int          DC   = LC + NW;          // edge after which done is high

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_writeback_if #(.K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  systolic_writeback_if #(.K(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  systolic_writeback #(
    .M(M), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_BASE(BASE), .LAT(LAT)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  systolic_writeback #(
    .M(1), .K(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_BASE(BASE), .LAT(0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Lane stimulus. mode 0: ramp tag {m,k} in-window, DEADBEEF outside.
  // mode 1: every lane carries the next row's tag, i.e. the right value one
  // cycle early, so only an exact-cycle capture writes {m+1,k}.
  // mode 2: fully random.
  function automatic logic [DW-1:0] lane_val(input int mode, input int c, input int k);
    int m;
    m = c - LAT - k;
    case (mode)
      0:       return (m >= 0 && m < M) ? {16'(m), 16'(k)} : 32'hDEAD_BEEF;
      1:       return {16'(m + 1), 16'(k)};
      default: return $urandom;
    endcase
  endfunction

  // One run of the 20x5 instance. p1/p2: extra start pulses at those edges.
  // rst_c: edge after which reset is asserted (-1 = none); run aborts there.
  task automatic run_main(input string tag, input int mode, input int p1, input int p2,
                          input int rst_c);
    logic [DW*K-1:0] ys [LC+1];
    logic [DW*K-1:0] junk;
    logic            exp_en;
    int              beef;
    beef = 0;
    for (int c = 0; c <= LC; c++)
      for (int k = 0; k < K; k++) ys[c][k*DW +: DW] = lane_val(mode, c, k);
    bus.Y     = ys[0];
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c <= DC + 3; c++) begin
      if (c == rst_c) begin
        rst = 1'b0;
        #1;
        chk({tag, " async rst en"},   64'(bus.mem_wr_en), 64'(0));
        chk({tag, " async rst addr"}, 64'(bus.addr_wr),   64'(0));
        chk({tag, " async rst data"}, 64'(bus.data_wr),   64'(0));
        chk({tag, " async rst done"}, 64'(bus.done),      64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          chk({tag, " post-rst idle"}, 64'({bus.mem_wr_en, bus.done}), 64'(0));
        end
        return;
      end
      exp_en = (c >= LC) && (c < LC + NW);
      chk({tag, " wr_en"}, 64'(bus.mem_wr_en), 64'(exp_en));
      if (exp_en) begin
        int j, m, k;
        j = c - LC;
        m = j / K;
        k = j % K;
        chk({tag, " addr"}, 64'(bus.addr_wr), 64'(BASE + 32'(j)));
        chk({tag, " data"}, 64'(bus.data_wr), 64'(ys[LAT + m + k][k*DW +: DW]));
        if (bus.data_wr == 32'hDEAD_BEEF) beef++;
      end
      chk({tag, " done"}, 64'(bus.done), 64'(c >= DC));
      for (int k = 0; k < K; k++) junk[k*DW +: DW] = $urandom;
      bus.Y     = (c + 1 <= LC) ? ys[c + 1] : junk;
      bus.start = (c + 1 == p1) || (c + 1 == p2);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    if (mode == 0) chk({tag, " DEADBEEF writes"}, 64'(beef), 64'(0));
  endtask

  typedef struct {
    logic [31:0] y;
    logic [31:0] y_after;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  initial begin
    vec_t tv [4];
    logic [31:0] r;
    r = $urandom;
    tv[0] = '{32'h0000_CAFE, 32'hDEAD_BEEF, 32'h0000_3000, 32'h0000_CAFE};
    tv[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_3000, 32'hFFFF_FFFF};
    tv[2] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_3000, 32'h0000_0000};
    tv[3] = '{r,             ~r,            32'h0000_3000, r};

    bus.start  = 1'b0;
    bus.Y      = '0;
    bus1.start = 1'b0;
    bus1.Y     = '0;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk("rst en",    64'(bus.mem_wr_en), 64'(0));
    chk("rst addr",  64'(bus.addr_wr),   64'(0));
    chk("rst data",  64'(bus.data_wr),   64'(0));
    chk("rst done",  64'(bus.done),      64'(0));
    chk("rst1 en",   64'(bus1.mem_wr_en), 64'(0));
    chk("rst1 addr", 64'(bus1.addr_wr),   64'(0));
    chk("rst1 data", 64'(bus1.data_wr),   64'(0));
    chk("rst1 done", 64'(bus1.done),      64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // 1x1, LAT=0: capture on the start edge, single write next cycle, done after edge 1.
    for (int i = 0; i < 4; i++) begin
      bus1.Y     = tv[i].y;
      bus1.start = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0;
      bus1.Y     = tv[i].y_after;
      chk("m1 c0 en",   64'(bus1.mem_wr_en), 64'(1));
      chk("m1 c0 addr", 64'(bus1.addr_wr),   64'(tv[i].exp_addr));
      chk("m1 c0 data", 64'(bus1.data_wr),   64'(tv[i].exp_data));
      chk("m1 c0 done", 64'(bus1.done),      64'(0));
      @(posedge clk); #1;
      chk("m1 c1 en",   64'(bus1.mem_wr_en), 64'(0));
      chk("m1 c1 done", 64'(bus1.done),      64'(1));
      @(posedge clk); #1;
      chk("m1 done held", 64'({bus1.done, bus1.mem_wr_en}), 64'(2'b10));
    end

    run_main("ramp",           0, -1, -1,      -1);
    run_main("ramp+start",     0, 20, LC + 5,  -1);  // begins in DONE: restart path
    run_main("rst in capture", 0, -1, -1,      15);
    run_main("ramp after rst", 0, -1, -1,      -1);
    run_main("rst in write",   2, -1, -1,      LC + 10);
    run_main("skew",           1, -1, -1,      -1);
    run_main("random a",       2, -1, -1,      -1);
    run_main("random b",       2, 3,  LC + NW - 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
